// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Iterative unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier.
// Revision : 1.0  initial release
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p,
    output logic                 rdy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_CNT_DONE = CW'(WIDTH);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic               r_rdy;

    // The multiplicand is pre-shifted and the multiplier consumed LSB-first,
    // which is equivalent to adding (a << counter) when b[counter] is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p      <= '0;
            r_rdy    <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
        end else if (r_cnt < c_CNT_DONE) begin
            if (r_mplier[0]) begin
                r_p <= r_p + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == c_CNT_LAST) begin
                r_rdy <= 1'b1;
            end
        end
    end

    assign p   = r_p;
    assign rdy = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier
// Purpose  : Scoreboard bench for seq_multiplier against a plain a*b model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic [2*W-1:0]  p;
    logic            rdy;

    int tests = 0;
    int fails = 0;

    logic [2*W-1:0] exp_q[$];
    int             cyc = 0;
    logic           rst_seen = 1'b1;
    logic           rdy_prev = 1'b0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .p     (p),
        .rdy   (rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Edges since the last reset-high edge, and whether that edge had reset.
    always @(posedge clk) begin
        rst_seen <= reset;
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: on each rdy rising edge pop the oldest expected product.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                check("reset_rdy", 64'(rdy), 64'd0);
                check("reset_p", p, 64'd0);
            end else if (rdy && !rdy_prev) begin
                check("latency", 64'(cyc), 64'd32);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rdy: got rdy=1 expected no result pending");
                end else begin
                    check("product", p, exp_q.pop_front());
                end
            end
            rdy_prev = rdy;
        end
    end

    // Hold reset for n cycles; the model uses the values on the last one.
    task automatic load(input logic [W-1:0] va, input logic [W-1:0] vb, input int n, input bit expect_done);
        reset = 1'b1;
        for (int i = 0; i < n - 1; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
        end
        a = va;
        b = vb;
        @(posedge clk); #1;
        reset = 1'b0;
        if (expect_done) exp_q.push_back({{W{1'b0}}, va} * {{W{1'b0}}, vb});
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy) break;
        end
        if (k == 40) begin
            tests++;
            fails++;
            $display("FAIL timeout: got rdy=0 after 40 cycles expected rdy=1");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2*W-1:0] model;

        // Basic
        load(32'd3, 32'd5, 2, 1'b1);
        wait_done();
        check("basic_p", p, 64'h0000_0000_0000_000F);

        // Max operands, word views
        load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1);
        wait_done();
        check("max_hi", 64'(p[63:32]), 64'h0000_0000_FFFF_FFFE);
        check("max_lo", 64'(p[31:0]),  64'h0000_0000_0000_0001);

        // Zero operand
        load(32'd0, 32'h1234_5678, 1, 1'b1);
        wait_done();
        check("zero_p", p, 64'd0);

        // Operand change after release is ignored
        load(32'h0001_0000, 32'h0001_0000, 1, 1'b1);
        a = 32'd7;
        b = 32'd9;
        wait_done();
        check("ignore_p", p, 64'h0000_0001_0000_0000);

        // Abort mid-operation
        load(32'd100, 32'd200, 1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        load(32'd6, 32'd7, 1, 1'b1);
        wait_done();
        check("abort_p", p, 64'd42);

        // Hold after done
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("hold_p", p, 64'd42);
        check("hold_rdy", 64'(rdy), 64'd1);
        @(posedge clk); #1;

        // Randomised operands and reset lengths
        for (int t = 0; t < 20; t++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (t % 5 == 0) rb = 32'h8000_0001;
            load(ra, rb, int'($urandom_range(1, 3)), 1'b1);
            a = W'($urandom);
            b = W'($urandom);
            wait_done();
            model = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            check("rand_final", p, model);
        end

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending: got %0d results outstanding expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
